// File: rtl/elevator_car_ctrl.sv
// elevator_car_ctrl: SCAN-scheduled elevator car FSM timed by the divider's slow clock.
// Optional macro ELEVATOR_ESTOP_EN adds an estop input that freezes motion and doors.
module elevator_car_ctrl #(
  parameter int NUM_FLOORS      = 4,
  parameter int TICKS_PER_FLOOR = 4,
  parameter int DOOR_TICKS      = 6,
  parameter int FW              = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  slow_in,
  input  logic [NUM_FLOORS-1:0] call_req,
`ifdef ELEVATOR_ESTOP_EN
  input  logic                  estop,
`endif
  output logic [FW-1:0]         cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int MW = (TICKS_PER_FLOOR > 1) ? $clog2(TICKS_PER_FLOOR) : 1;
  localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [MW-1:0] MV_LAST = MW'(TICKS_PER_FLOOR - 1);
  localparam logic [DW-1:0] DR_LAST = DW'(DOOR_TICKS - 1);
  localparam logic [FW-1:0] TOP     = FW'(NUM_FLOORS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE_UP,
    S_MOVE_DOWN,
    S_DOOR_OPEN
  } state_t;

  state_t                  r_state, w_state;
  logic [FW-1:0]           r_floor, w_floor;
  logic                    r_dir, w_dir;
  logic [NUM_FLOORS-1:0]   r_pend, w_pend;
  logic [MW-1:0]           r_mv_cnt, w_mv_cnt;
  logic [DW-1:0]           r_door_cnt, w_door_cnt;
  logic                    r_slow_prev;

  logic                    w_tick;
  logic [NUM_FLOORS-1:0]   w_eff;
  logic                    w_above, w_below, w_here;
  logic [FW-1:0]           w_step_floor;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_floor     <= '0;
      r_dir       <= 1'b1;
      r_pend      <= '0;
      r_mv_cnt    <= '0;
      r_door_cnt  <= '0;
      r_slow_prev <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_floor     <= w_floor;
      r_dir       <= w_dir;
      r_pend      <= w_pend;
      r_mv_cnt    <= w_mv_cnt;
      r_door_cnt  <= w_door_cnt;
      r_slow_prev <= slow_in;
    end
  end

  always_comb begin
    w_tick  = slow_in & ~r_slow_prev;
    w_eff   = r_pend | call_req;
    w_above = 1'b0;
    w_below = 1'b0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (w_eff[f] && (f > int'(r_floor))) w_above = 1'b1;
      if (w_eff[f] && (f < int'(r_floor))) w_below = 1'b1;
    end
    w_here = w_eff[r_floor];
    // Saturating step: the car never wraps past either end
    if (r_state == S_MOVE_UP)
      w_step_floor = (r_floor == TOP) ? r_floor : r_floor + FW'(1);
    else
      w_step_floor = (r_floor == '0) ? r_floor : r_floor - FW'(1);
  end

  always_comb begin
    w_state    = r_state;
    w_floor    = r_floor;
    w_dir      = r_dir;
    w_pend     = w_eff;
    w_mv_cnt   = r_mv_cnt;
    w_door_cnt = r_door_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_here) begin
          w_pend[r_floor] = 1'b0;
          w_door_cnt      = '0;
          w_state         = S_DOOR_OPEN;
        end else if (w_above && (r_dir || !w_below)) begin
          w_state = S_MOVE_UP;
          w_dir   = 1'b1;
        end else if (w_below) begin
          w_state = S_MOVE_DOWN;
          w_dir   = 1'b0;
        end
      end
      S_MOVE_UP, S_MOVE_DOWN: begin
        if (w_tick) begin
          if (r_mv_cnt == MV_LAST) begin
            w_mv_cnt = '0;
            w_floor  = w_step_floor;
            if (w_eff[w_step_floor]) begin
              w_pend[w_step_floor] = 1'b0;
              w_door_cnt           = '0;
              w_state              = S_DOOR_OPEN;
            end
          end else begin
            w_mv_cnt = r_mv_cnt + MW'(1);
          end
        end
      end
      S_DOOR_OPEN: begin
        // A fresh call at this floor re-opens the door
        if (w_here) begin
          w_pend[r_floor] = 1'b0;
          w_door_cnt      = '0;
        end else if (w_tick) begin
          if (r_door_cnt == DR_LAST) w_state = S_IDLE;
          else w_door_cnt = r_door_cnt + DW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
`ifdef ELEVATOR_ESTOP_EN
    if (estop) begin
      w_state    = r_state;
      w_floor    = r_floor;
      w_dir      = r_dir;
      w_mv_cnt   = r_mv_cnt;
      w_door_cnt = r_door_cnt;
      w_pend     = w_eff;
    end
`endif
  end

  assign cur_floor = r_floor;
  assign dir_up    = r_dir;
  assign moving    = (r_state == S_MOVE_UP) || (r_state == S_MOVE_DOWN);
  assign door_open = (r_state == S_DOOR_OPEN);
  assign pending   = r_pend;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb_elevator_car_ctrl: random + directed stimulus, scoreboard against a
// tick-countdown reference model of the SCAN elevator.
module tb_elevator_car_ctrl;

  localparam int NF  = 4;
  localparam int TPF = 2;
  localparam int DT  = 3;
  localparam int FW  = 2;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;
  localparam int M_DOOR = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          slow_in = 1'b0;
  logic [NF-1:0] call_req = '0;
`ifdef ELEVATOR_ESTOP_EN
  logic          estop = 1'b0;
`endif
  logic [FW-1:0] cur_floor;
  logic          dir_up, moving, door_open;
  logic [NF-1:0] pending;

  elevator_car_ctrl #(
    .NUM_FLOORS(NF),
    .TICKS_PER_FLOOR(TPF),
    .DOOR_TICKS(DT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .slow_in(slow_in),
    .call_req(call_req),
`ifdef ELEVATOR_ESTOP_EN
    .estop(estop),
`endif
    .cur_floor(cur_floor),
    .dir_up(dir_up),
    .moving(moving),
    .door_open(door_open),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    int      floor;
    bit      dir;
    bit      mv;
    bit      door;
    bit [NF-1:0] pend;
    string   tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   phase_cnt = 0;
  string tag = "init";

  // Reference model: floors as ints, travel/door time as countdowns
  int      m_floor, m_mode, m_left;
  bit      m_dir, m_prev;
  bit [NF-1:0] m_pend;

  function automatic void model_reset();
    m_floor = 0; m_mode = M_IDLE; m_left = 0;
    m_dir = 1'b1; m_prev = 1'b0; m_pend = '0;
  endfunction

  function automatic void model_step(bit rst, bit slow, bit [NF-1:0] call,
                                     bit stop);
    bit tick;
    bit [NF-1:0] eff;
    bit up, dn;
    if (rst) begin
      model_reset();
      return;
    end
    tick = slow && !m_prev;
    m_prev = slow;
    eff = m_pend | call;
    if (stop) begin
      m_pend = eff;
      return;
    end
    up = 0; dn = 0;
    for (int f = 0; f < NF; f++) begin
      if (eff[f] && f > m_floor) up = 1;
      if (eff[f] && f < m_floor) dn = 1;
    end
    case (m_mode)
      M_IDLE: begin
        if (eff[m_floor]) begin
          eff[m_floor] = 0; m_mode = M_DOOR; m_left = DT;
        end else if (up && (m_dir || !dn)) begin
          m_mode = M_UP; m_dir = 1; m_left = TPF;
        end else if (dn) begin
          m_mode = M_DOWN; m_dir = 0; m_left = TPF;
        end
      end
      M_UP, M_DOWN: begin
        if (tick) begin
          m_left--;
          if (m_left == 0) begin
            if (m_mode == M_UP && m_floor < NF - 1) m_floor++;
            if (m_mode == M_DOWN && m_floor > 0) m_floor--;
            if (eff[m_floor]) begin
              eff[m_floor] = 0; m_mode = M_DOOR; m_left = DT;
            end else begin
              m_left = TPF;
            end
          end
        end
      end
      default: begin
        if (eff[m_floor]) begin
          eff[m_floor] = 0; m_left = DT;
        end else if (tick) begin
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
      end
    endcase
    m_pend = eff;
  endfunction

  task automatic drive(input bit rst, input bit [NF-1:0] call, input bit stop);
    exp_t e;
    @(negedge clk);
    slow_in = ((phase_cnt % 8) >= 4);
    phase_cnt++;
    reset = rst;
    call_req = call;
`ifdef ELEVATOR_ESTOP_EN
    estop = stop;
`endif
    model_step(rst, slow_in, call, stop);
    e.floor = m_floor;
    e.dir   = m_dir;
    e.mv    = (m_mode == M_UP) || (m_mode == M_DOWN);
    e.door  = (m_mode == M_DOOR);
    e.pend  = m_pend;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (int'(cur_floor) != e.floor || dir_up != e.dir ||
            moving != e.mv || door_open != e.door || pending != e.pend) begin
          errors++;
          if (errors <= 30)
            $display("FAIL %s t=%0t: got floor=%0d dir=%b mv=%b door=%b pend=%b, exp floor=%0d dir=%b mv=%b door=%b pend=%b",
                     e.tag, $time, cur_floor, dir_up, moving, door_open, pending,
                     e.floor, e.dir, e.mv, e.door, e.pend);
        end
      end
    end
  end

  initial begin
    bit [NF-1:0] c;
    bit          s;
    int          burst;
    int          guard;
    model_reset();

    tag = "reset";
    for (int i = 0; i < 3; i++) drive(1'b1, '0, 1'b0);
    idle(6);

    tag = "door_f0";
    drive(1'b0, 4'b0001, 1'b0);
    idle(40);

    tag = "move_f2";
    drive(1'b0, 4'b0100, 1'b0);
    idle(60);

    tag = "scan";
    drive(1'b1, '0, 1'b0);
    drive(1'b0, 4'b1000, 1'b0);
    guard = 0;
    while (m_floor != 1 && guard < 100) begin
      idle(1);
      guard++;
    end
    drive(1'b0, 4'b0101, 1'b0);
    idle(200);

    tag = "midreset";
    drive(1'b1, '0, 1'b0);
    drive(1'b0, 4'b1000, 1'b0);
    guard = 0;
    while (!(m_floor == 2 && m_left == 1) && guard < 100) begin
      idle(1);
      guard++;
    end
    drive(1'b1, '0, 1'b0);
    idle(40);

`ifdef ELEVATOR_ESTOP_EN
    tag = "estop";
    drive(1'b0, 4'b0100, 1'b0);
    idle(3);
    for (int i = 0; i < 40; i++)
      drive(1'b0, (i == 10) ? 4'b0010 : 4'b0000, 1'b1);
    idle(80);
`endif

    tag = "random";
    c = '0;
    burst = 0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 11) == 0) c = 4'($urandom);
      else if ($urandom_range(0, 3) != 0) c = '0;
      s = 1'b0;
`ifdef ELEVATOR_ESTOP_EN
      if (burst == 0 && $urandom_range(0, 299) == 0)
        burst = $urandom_range(5, 60);
      if (burst > 0) begin
        s = 1'b1;
        burst--;
      end
`endif
      drive($urandom_range(0, 699) == 0, c, s);
    end
    idle(5);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
